// File: rtl/bus_slave_responder.sv
// Responder end of the single-master bus: decodes RB/WB strobes for DEVICE_ID,
// parity-checks writes into a holding register and answers reads with an ack handshake.
module bus_slave_responder #(
  parameter int unsigned                     DATA_BUS_WIDTH = 32,
  parameter int unsigned                     ADDR_BUS_WIDTH = 8,
  parameter int unsigned                     ERR_CNT_WIDTH  = 8,
  parameter logic [ADDR_BUS_WIDTH-1:0]       DEVICE_ID      = 'h01,
  parameter logic [DATA_BUS_WIDTH-1:0]       RESET_DATA     = '0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [ADDR_BUS_WIDTH-1:0] address,
  input  logic                      rb,
  input  logic                      wb,
  input  logic [DATA_BUS_WIDTH-1:0] data_in,
  input  logic                      parity_in,
  output logic [DATA_BUS_WIDTH-1:0] data_out,
  output logic                      parity_out,
  output logic                      data_oe,
  output logic                      ack,
  output logic                      busy,
  output logic [DATA_BUS_WIDTH-1:0] stored_data,
  output logic [ERR_CNT_WIDTH-1:0]  parity_err_cnt,
  output logic                      proto_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACK_W    = 3'd1,
    DRIVE    = 3'd2,
    ACK_R    = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  state_t                    state_q;
  logic [DATA_BUS_WIDTH-1:0] data_out_q;
  logic                      parity_out_q;
  logic                      data_oe_q;
  logic                      ack_q;
  logic                      busy_q;
  logic [DATA_BUS_WIDTH-1:0] stored_q;
  logic [ERR_CNT_WIDTH-1:0]  err_cnt_q;
  logic                      proto_err_q;

  logic hit;
  logic parity_ok;

  assign hit       = (address == DEVICE_ID);
  assign parity_ok = ((^data_in) == parity_in);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      data_out_q   <= '0;
      parity_out_q <= 1'b0;
      data_oe_q    <= 1'b0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      stored_q     <= RESET_DATA;
      err_cnt_q    <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            if (wb && !rb) begin
              state_q <= ACK_W;
              busy_q  <= 1'b1;
              ack_q   <= 1'b1;
              // A rejected write is still acked; only the counter records it.
              if (parity_ok) begin
                stored_q <= data_in;
              end else if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 1'b1;
              end
            end else if (rb && !wb) begin
              state_q      <= DRIVE;
              busy_q       <= 1'b1;
              data_out_q   <= stored_q;
              parity_out_q <= ^stored_q;
              data_oe_q    <= 1'b1;
            end else if (rb && wb) begin
              state_q     <= WAIT_REL;
              busy_q      <= 1'b1;
              proto_err_q <= 1'b1;
            end
          end
        end
        ACK_W: begin
          state_q <= WAIT_REL;
          ack_q   <= 1'b0;
        end
        DRIVE: begin
          state_q <= ACK_R;
          ack_q   <= 1'b1;
        end
        ACK_R: begin
          state_q      <= WAIT_REL;
          ack_q        <= 1'b0;
          data_oe_q    <= 1'b0;
          data_out_q   <= '0;
          parity_out_q <= 1'b0;
        end
        WAIT_REL: begin
          // Holding here until both strobes drop turns a held strobe into one transaction.
          if (!rb && !wb) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out       = data_out_q;
  assign parity_out     = parity_out_q;
  assign data_oe        = data_oe_q;
  assign ack            = ack_q;
  assign busy           = busy_q;
  assign stored_data    = stored_q;
  assign parity_err_cnt = err_cnt_q;
  assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_bus_slave_responder.sv
// Scoreboard bench for bus_slave_responder: writes/reads push expected data,
// completed transactions pop and compare.
module tb_bus_slave_responder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  address;
  logic        rb, wb;
  logic [31:0] data_in;
  logic        parity_in;
  logic [31:0] data_out;
  logic        parity_out, data_oe, ack, busy;
  logic [31:0] stored_data;
  logic [7:0]  parity_err_cnt;
  logic        proto_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb_q[$];
  logic [31:0] model_stored;
  logic [7:0]  model_cnt;

  bus_slave_responder dut (
    .clock(clock), .reset_n(reset_n), .address(address), .rb(rb), .wb(wb),
    .data_in(data_in), .parity_in(parity_in), .data_out(data_out),
    .parity_out(parity_out), .data_oe(data_oe), .ack(ack), .busy(busy),
    .stored_data(stored_data), .parity_err_cnt(parity_err_cnt), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  // Drive one strobe pattern for `hold` edges, drop strobes, then run until idle.
  task automatic run_txn(input logic [7:0] a, input logic r, input logic w,
                         input logic [31:0] d, input logic p, input int hold,
                         output int ack_cnt, output int ack_first,
                         output int oe_cnt, output int oe_first,
                         output logic [31:0] dout_at_ack, output logic pout_at_ack,
                         output int busy_cnt, output bit timeout);
    int cyc;
    bit done;
    ack_cnt = 0; ack_first = -1; oe_cnt = 0; oe_first = -1;
    dout_at_ack = '0; pout_at_ack = 1'b0; busy_cnt = 0; timeout = 1'b0;
    cyc = 0; done = 1'b0;
    @(negedge clock);
    address = a; rb = r; wb = w; data_in = d; parity_in = p;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      if (ack) begin
        ack_cnt++;
        if (ack_first < 0) ack_first = cyc;
        dout_at_ack = data_out; pout_at_ack = parity_out;
      end
      if (data_oe) begin oe_cnt++; if (oe_first < 0) oe_first = cyc; end
      if (busy) busy_cnt++;
      cyc++;
    end
    @(negedge clock);
    rb = 1'b0; wb = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clock); #1;
      if (ack) begin
        ack_cnt++;
        if (ack_first < 0) ack_first = cyc;
        dout_at_ack = data_out; pout_at_ack = parity_out;
      end
      if (data_oe) begin oe_cnt++; if (oe_first < 0) oe_first = cyc; end
      if (busy) busy_cnt++;
      else done = 1'b1;
      cyc++;
    end
    if (!done) timeout = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; address = '0; rb = 0; wb = 0; data_in = '0; parity_in = 0;
    repeat (2) @(posedge clock);
    #1;
    model_stored = '0; model_cnt = '0;
    checks++;
    if ({data_out, parity_out, data_oe, ack, busy, proto_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got dout=%h par=%b oe=%b ack=%b busy=%b perr=%b exp all 0",
               data_out, parity_out, data_oe, ack, busy, proto_err);
    end
    checks++;
    if (stored_data !== model_stored || parity_err_cnt !== model_cnt) begin
      failures++;
      $display("FAIL reset_state got stored=%h cnt=%0d exp stored=%h cnt=%0d",
               stored_data, parity_err_cnt, model_stored, model_cnt);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_write(input logic [31:0] d, input logic p, input string tag);
    int ac, af, oc, of, bc; logic [31:0] da; logic pa; bit to;
    logic [31:0] exp;
    if ((^d) == p) model_stored = d;
    else if (model_cnt != 8'hFF) model_cnt++;
    sb_q.push_back(model_stored);
    run_txn(8'h01, 1'b0, 1'b1, d, p, 3, ac, af, oc, of, da, pa, bc, to);
    exp = sb_q.pop_front();
    $display("write %s data=%h par=%b ack_cnt=%0d stored=%h cnt=%0d", tag, d, p, ac, stored_data, parity_err_cnt);
    checks++;
    if (to) begin failures++; $display("FAIL %s_timeout got busy stuck exp idle", tag); end
    checks++;
    if (ac != 1 || af != 0) begin
      failures++;
      $display("FAIL %s_ack got count=%0d first=%0d exp count=1 first=0", tag, ac, af);
    end
    checks++;
    if (stored_data !== exp) begin
      failures++; $display("FAIL %s_stored got %h exp %h", tag, stored_data, exp);
    end
    checks++;
    if (parity_err_cnt !== model_cnt) begin
      failures++; $display("FAIL %s_errcnt got %0d exp %0d", tag, parity_err_cnt, model_cnt);
    end
  endtask

  task automatic test_read(input string tag);
    int ac, af, oc, of, bc; logic [31:0] da; logic pa; bit to;
    logic [31:0] exp;
    sb_q.push_back(model_stored);
    run_txn(8'h01, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 3, ac, af, oc, of, da, pa, bc, to);
    exp = sb_q.pop_front();
    $display("read %s data=%h par=%b oe_cycles=%0d ack_cnt=%0d", tag, da, pa, oc, ac);
    checks++;
    if (to) begin failures++; $display("FAIL %s_timeout got busy stuck exp idle", tag); end
    checks++;
    if (oc != 2 || of != 0) begin
      failures++; $display("FAIL %s_oe got cycles=%0d first=%0d exp 2/0", tag, oc, of);
    end
    checks++;
    if (ac != 1 || af != 1) begin
      failures++; $display("FAIL %s_ack got count=%0d first=%0d exp 1/1", tag, ac, af);
    end
    checks++;
    if (da !== exp || pa !== ^exp) begin
      failures++; $display("FAIL %s_data got %h/%b exp %h/%b", tag, da, pa, exp, ^exp);
    end
    checks++;
    if (data_oe !== 1'b0 || data_out !== '0) begin
      failures++; $display("FAIL %s_release got oe=%b dout=%h exp 0/0", tag, data_oe, data_out);
    end
  endtask

  task automatic test_parity_saturate();
    int ac, af, oc, of, bc; logic [31:0] da; logic pa; bit to;
    int acks = 0;
    bit any_to = 0;
    for (int i = 0; i < 255; i++) begin
      run_txn(8'h01, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 2, ac, af, oc, of, da, pa, bc, to);
      acks += ac;
      if (to) any_to = 1;
      if (model_cnt != 8'hFF) model_cnt++;
    end
    $display("saturate writes=255 acks=%0d cnt=%h stored=%h", acks, parity_err_cnt, stored_data);
    checks++;
    if (any_to || acks != 255) begin
      failures++; $display("FAIL sat_acks got %0d timeout=%b exp 255/0", acks, any_to);
    end
    checks++;
    if (parity_err_cnt !== model_cnt || model_cnt !== 8'hFF) begin
      failures++; $display("FAIL sat_errcnt got %h exp %h", parity_err_cnt, model_cnt);
    end
    checks++;
    if (stored_data !== model_stored) begin
      failures++; $display("FAIL sat_stored got %h exp %h", stored_data, model_stored);
    end
  endtask

  task automatic test_addr_miss();
    int ac, af, oc, of, bc; logic [31:0] da; logic pa; bit to;
    for (int k = 0; k < 2; k++) begin
      run_txn(8'h02, k[0], ~k[0], 32'h1234_5678, 1'b1, 5, ac, af, oc, of, da, pa, bc, to);
      $display("miss %s ack_cnt=%0d oe_cycles=%0d busy_cycles=%0d", k ? "rb" : "wb", ac, oc, bc);
      checks++;
      if (ac != 0 || oc != 0 || bc != 0 || to) begin
        failures++;
        $display("FAIL miss_quiet got ack=%0d oe=%0d busy=%0d to=%b exp 0/0/0/0", ac, oc, bc, to);
      end
      checks++;
      if (stored_data !== model_stored) begin
        failures++; $display("FAIL miss_stored got %h exp %h", stored_data, model_stored);
      end
    end
  endtask

  task automatic test_held_strobe();
    int ac, af, oc, of, bc; logic [31:0] da; logic pa; bit to;
    run_txn(8'h01, 1'b1, 1'b0, '0, 1'b0, 10, ac, af, oc, of, da, pa, bc, to);
    $display("held rb=10 ack_cnt=%0d busy_cycles=%0d data=%h", ac, bc, da);
    checks++;
    if (ac != 1 || bc != 10 || to) begin
      failures++; $display("FAIL held_once got ack=%0d busy=%0d to=%b exp 1/10/0", ac, bc, to);
    end
  endtask

  task automatic test_proto_err();
    int ac, af, oc, of, bc; logic [31:0] da; logic pa; bit to;
    run_txn(8'h01, 1'b1, 1'b1, 32'hFFFF_0000, 1'b0, 3, ac, af, oc, of, da, pa, bc, to);
    $display("proto rb=wb=1 ack_cnt=%0d oe=%0d proto_err=%b busy=%b", ac, oc, proto_err, busy);
    checks++;
    if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_flag got %b exp 1", proto_err); end
    checks++;
    if (ac != 0 || oc != 0 || bc != 3 || to || busy !== 1'b0) begin
      failures++;
      $display("FAIL proto_seq got ack=%0d oe=%0d busy_cycles=%0d to=%b exp 0/0/3/0", ac, oc, bc, to);
    end
    checks++;
    if (stored_data !== model_stored) begin
      failures++; $display("FAIL proto_stored got %h exp %h", stored_data, model_stored);
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clock);
    address = 8'h01; rb = 1'b1; wb = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (data_oe !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL rst_pre_drive got oe=%b busy=%b exp 1/1", data_oe, busy);
    end
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock); #1;
    model_stored = '0; model_cnt = '0;
    $display("reset mid-read oe=%b ack=%b busy=%b stored=%h perr=%b", data_oe, ack, busy, stored_data, proto_err);
    checks++;
    if (data_oe !== 0 || ack !== 0 || busy !== 0 || proto_err !== 0 || stored_data !== model_stored
        || parity_err_cnt !== model_cnt) begin
      failures++;
      $display("FAIL rst_mid got oe=%b ack=%b busy=%b perr=%b stored=%h cnt=%0d exp all 0",
               data_oe, ack, busy, proto_err, stored_data, parity_err_cnt);
    end
    @(negedge clock);
    rb = 1'b0; reset_n = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || ack !== 1'b0) begin
      failures++; $display("FAIL rst_after got busy=%b ack=%b exp 0/0", busy, ack);
    end
  endtask

  initial begin
    logic [31:0] pat [3];
    pat[0] = 32'hA5A5_0001; pat[1] = 32'h8000_0000; pat[2] = 32'hFFFF_FFFF;
    test_reset();
    test_write(32'h0000_0003, 1'b0, "valid");
    test_read("readback");
    test_write(32'h0000_0001, 1'b0, "badpar");
    test_read("after_bad");
    for (int i = 0; i < 3; i++) begin
      test_write(pat[i], ^pat[i], "pattern");
      test_read("pattern");
    end
    test_parity_saturate();
    test_addr_miss();
    test_held_strobe();
    test_proto_err();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got time=%0t exp finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
